// File: rtl/alu_command_sequencer.sv
// alu_command_sequencer: accepts one ALU command, drives it onto the
// ArithmeticUnit input bus, waits a fixed settle time, then captures the
// ALU result plus C/V/N/Z flags and returns them on a response channel.
module alu_command_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clock,
    input  logic       nReset,
    input  logic       cmdValid,
    output logic       cmdReady,
    input  logic [2:0] cmdOpcode,
    input  logic [7:0] cmdOperandA,
    input  logic [7:0] cmdOperandB,
    output logic [2:0] aluOpcode,
    output logic [7:0] aluOperandA,
    output logic [7:0] aluOperandB,
    input  logic [7:0] aluResult,
    output logic       rspValid,
    input  logic       rspReady,
    output logic [7:0] rspResult,
    output logic [3:0] rspFlags,
    output logic       busy
);

    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       accept, capture;
    logic [8:0] sum9;
    logic       flag_c, flag_v, flag_n, flag_z;

    // Handshake outputs are pure decodes of the state register.
    assign cmdReady = (state == IDLE);
    assign rspValid = (state == RESP);
    assign busy     = (state != IDLE);

    // Next-state, settle counter and datapath enables.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (cmdValid) begin
                    accept    = 1'b1;
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (rspReady) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Flags come from the registered operands and the ALU's own result;
    // the ALU result itself is never second-guessed.
    always_comb begin
        sum9   = {1'b0, aluOperandA} + {1'b0, aluOperandB};
        flag_z = (aluResult == 8'h00);
        flag_n = aluResult[7];
        flag_c = 1'b0;
        flag_v = 1'b0;
        case (aluOpcode)
            OP_ADD: begin
                flag_c = sum9[8];
                flag_v = (aluOperandA[7] == aluOperandB[7]) && (aluResult[7] != aluOperandA[7]);
            end
            OP_SUB: begin
                flag_c = (aluOperandA < aluOperandB);
                flag_v = (aluOperandA[7] != aluOperandB[7]) && (aluResult[7] != aluOperandA[7]);
            end
            default: begin
                flag_c = 1'b0;
                flag_v = 1'b0;
            end
        endcase
    end

    // State and settle counter registers.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ALU bus registers hold their last command after the response is consumed.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            aluOpcode   <= '0;
            aluOperandA <= '0;
            aluOperandB <= '0;
        end else if (accept) begin
            aluOpcode   <= cmdOpcode;
            aluOperandA <= cmdOperandA;
            aluOperandB <= cmdOperandB;
        end
    end

    // Response registers are loaded once per command and held through backpressure.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            rspResult <= '0;
            rspFlags  <= '0;
        end else if (capture) begin
            rspResult <= aluResult;
            rspFlags  <= {flag_c, flag_v, flag_n, flag_z};
        end
    end

endmodule

// File: tb/tb_alu_command_sequencer.sv
// Scoreboard bench for alu_command_sequencer with a behavioural ALU model.
module tb_alu_command_sequencer;

    localparam int unsigned S = 3;

    logic       clock;
    logic       nReset;
    logic       cmdValid;
    logic       cmdReady;
    logic [2:0] cmdOpcode;
    logic [7:0] cmdOperandA;
    logic [7:0] cmdOperandB;
    logic [2:0] aluOpcode;
    logic [7:0] aluOperandA;
    logic [7:0] aluOperandB;
    logic [7:0] aluResult;
    logic       rspValid;
    logic       rspReady;
    logic [7:0] rspResult;
    logic [3:0] rspFlags;
    logic       busy;

    int tests = 0;
    int fails = 0;

    logic [11:0] exp_q[$];
    logic [11:0] cur_exp;
    logic        in_rsp   = 1'b0;
    logic        have_exp = 1'b0;

    alu_command_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clock       (clock),
        .nReset      (nReset),
        .cmdValid    (cmdValid),
        .cmdReady    (cmdReady),
        .cmdOpcode   (cmdOpcode),
        .cmdOperandA (cmdOperandA),
        .cmdOperandB (cmdOperandB),
        .aluOpcode   (aluOpcode),
        .aluOperandA (aluOperandA),
        .aluOperandB (aluOperandB),
        .aluResult   (aluResult),
        .rspValid    (rspValid),
        .rspReady    (rspReady),
        .rspResult   (rspResult),
        .rspFlags    (rspFlags),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Combinational ArithmeticUnit model: ADD, SUB, otherwise pass A.
    always_comb begin
        case (aluOpcode)
            3'b100:  aluResult = aluOperandA + aluOperandB;
            3'b101:  aluResult = aluOperandA - aluOperandB;
            default: aluResult = aluOperandA;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop one expectation per response, compare every cycle it is held.
    always @(negedge clock) begin
        if (rspValid) begin
            if (!in_rsp) begin
                in_rsp = 1'b1;
                if (exp_q.size() == 0) begin
                    have_exp = 1'b0;
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp: got result 0x%0h, expected no response", rspResult);
                end else begin
                    cur_exp  = exp_q.pop_front();
                    have_exp = 1'b1;
                end
            end
            if (have_exp) begin
                check("rspResult", 32'(rspResult), 32'(cur_exp[11:4]));
                check("rspFlags",  32'(rspFlags),  32'(cur_exp[3:0]));
            end
        end else begin
            in_rsp = 1'b0;
        end
    end

    // Present a command and return #1 after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] res, input logic [3:0] flg);
        int n;
        exp_q.push_back({res, flg});
        cmdOpcode   = op;
        cmdOperandA = a;
        cmdOperandB = b;
        cmdValid    = 1'b1;
        n = 0;
        while (!cmdReady && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (!cmdReady) check("cmd_accept_timeout", 32'(cmdReady), 32'd1);
        @(posedge clock); #1;
        cmdValid = 1'b0;
    endtask

    // Called #1 after acceptance; checks response latency in edges.
    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rspValid && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check("rsp_latency", 32'(n), 32'(S));
    endtask

    initial begin
        nReset      = 1'b0;
        cmdValid    = 1'b0;
        cmdOpcode   = '0;
        cmdOperandA = '0;
        cmdOperandB = '0;
        rspReady    = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset_rspValid", 32'(rspValid), 32'd0);
        check("reset_busy",     32'(busy),     32'd0);
        check("reset_aluOpA",   32'(aluOperandA), 32'd0);
        nReset = 1'b1;
        @(posedge clock); #1;
        check("post_reset_cmdReady", 32'(cmdReady), 32'd1);

        // Reset during SETTLE drops the command entirely.
        issue(3'b100, 8'h12, 8'h34, 8'h46, 4'b0000);
        @(posedge clock); #1;
        nReset = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_busy",     32'(busy),        32'd0);
        check("midrst_rspValid", 32'(rspValid),    32'd0);
        check("midrst_aluOp",    32'(aluOpcode),   32'd0);
        check("midrst_aluA",     32'(aluOperandA), 32'd0);
        check("midrst_aluB",     32'(aluOperandB), 32'd0);
        check("midrst_result",   32'(rspResult),   32'd0);
        check("midrst_flags",    32'(rspFlags),    32'd0);
        @(negedge clock);
        nReset = 1'b1;
        for (int i = 0; i < int'(S) + 3; i++) begin
            @(posedge clock); #1;
            check("midrst_no_rsp", 32'(rspValid), 32'd0);
        end
        check("midrst_cmdReady", 32'(cmdReady), 32'd1);

        // Directed vectors: {op, A, B} -> {result, C V N Z}.
        issue(3'b100, 8'hFF, 8'h55, 8'h54, 4'b1000); wait_rsp();
        issue(3'b101, 8'h00, 8'h55, 8'hAB, 4'b1010); wait_rsp();
        issue(3'b101, 8'h0F, 8'h55, 8'hBA, 4'b1010); wait_rsp();
        issue(3'b100, 8'h7F, 8'h01, 8'h80, 4'b0110); wait_rsp();
        issue(3'b101, 8'h80, 8'h01, 8'h7F, 4'b0100); wait_rsp();
        issue(3'b100, 8'h00, 8'h00, 8'h00, 4'b0001); wait_rsp();
        issue(3'b000, 8'h00, 8'h00, 8'h00, 4'b0001); wait_rsp();
        issue(3'b001, 8'h85, 8'hF0, 8'h85, 4'b0010); wait_rsp();
        @(posedge clock); #1;
        check("alu_hold_opA", 32'(aluOperandA), 32'h85);

        // Backpressure with a second command waiting.
        rspReady = 1'b0;
        issue(3'b100, 8'h40, 8'h40, 8'h80, 4'b0110);
        exp_q.push_back({8'h00, 4'b0001});
        cmdOpcode   = 3'b101;
        cmdOperandA = 8'h10;
        cmdOperandB = 8'h10;
        cmdValid    = 1'b1;
        wait_rsp();
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check("bp_cmdReady", 32'(cmdReady), 32'd0);
            check("bp_rspValid", 32'(rspValid), 32'd1);
        end
        rspReady = 1'b1;
        @(posedge clock); #1;
        check("consume_rspValid", 32'(rspValid), 32'd0);
        check("consume_cmdReady", 32'(cmdReady), 32'd1);
        @(posedge clock); #1;
        check("second_accepted", 32'(busy), 32'd1);
        cmdValid = 1'b0;
        wait_rsp();

        repeat (3) @(posedge clock);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
